button_debounce_bank: RTL and testbench

Multi-channel pushbutton front end that replaces single-button, raw-input LED following. Each channel:
- synchronises an asynchronous button input;
- debounces it with a programmable stability window;
- emits one-cycle press, release and long-press pulses;
- drives an LED output in either follow or toggle mode, selectable per channel at run time.

It sits between board pins and user-interface logic; all outputs are clean, synchronous to `clk`.

---
 rtl/debounce_pkg.sv | 24 ++
 rtl/debounce_channel.sv | 112 +++++++++++
 rtl/button_debounce_bank.sv | 41 ++++
 tb/tb_button_debounce_bank.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the pushbutton debounce bank.
package debounce_pkg;

  typedef enum logic {
    MODE_FOLLOW = 1'b0,
    MODE_TOGGLE = 1'b1
  } led_mode_e;

  typedef enum logic {
    BTN_IDLE    = 1'b0,
    BTN_PRESSED = 1'b1
  } btn_state_e;

  // Debounce counter only ever reaches DEBOUNCE_CYC-1, so $clog2(DEBOUNCE_CYC) bits suffice.
  function automatic int cnt_w(input int debounce_cyc);
    return (debounce_cyc <= 2) ? 1 : $clog2(debounce_cyc);
  endfunction

  // Hold counter saturates at LONG_CYC inclusive; a disabled (0) window still needs a legal width.
  function automatic int hold_w(input int long_cyc);
    return (long_cyc <= 1) ? 1 : $clog2(long_cyc + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, debounce window, press/release/hold strobes, LED drive.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int LONG_CYC     = 50000,
  parameter bit ACTIVE_HIGH  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  input  logic mode_i,
  output logic btn_state_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o,
  output logic led_o
);

  localparam int CW = cnt_w(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic                   btn_pol;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  btn_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   led_q, led_d;
  logic                   hold_q;
  logic                   mismatch, accept;
  led_mode_e              mode;

  assign btn_pol = ACTIVE_HIGH ? btn_i : ~btn_i;
  assign sync    = sync_q[SYNC_STAGES-1];
  assign mode    = led_mode_e'(mode_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_pol};
  end

  // Any cycle of agreement restarts the window; acceptance also clears it.
  always_comb begin
    mismatch  = sync != (state_q == BTN_PRESSED);
    accept    = mismatch && (cnt_q == CNT_LAST);
    cnt_d     = (!mismatch || accept) ? '0 : cnt_q + CW'(1);
    state_d   = state_q;
    if (accept) state_d = (state_q == BTN_PRESSED) ? BTN_IDLE : BTN_PRESSED;
    press_d   = accept && (state_q == BTN_IDLE);
    release_d = accept && (state_q == BTN_PRESSED);
    if (mode == MODE_FOLLOW) led_d = (state_d == BTN_PRESSED);
    else                     led_d = press_d ? ~led_q : led_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BTN_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      led_q     <= led_d;
    end
  end

  generate
    if (LONG_CYC > 0) begin : g_hold
      localparam int HW = hold_w(LONG_CYC);
      localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
      localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYC - 1);

      logic [HW-1:0] hold_cnt_q, hold_cnt_d;
      logic          hold_d;

      // Counts edges spent pressed; fires on the edge that brings the count to LONG_CYC.
      always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_q == BTN_IDLE)        hold_cnt_d = '0;
        else if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + HW'(1);
        hold_d = (state_q == BTN_PRESSED) && (hold_cnt_q == HOLD_FIRE);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_cnt_q <= '0;
          hold_q     <= 1'b0;
        end else begin
          hold_cnt_q <= hold_cnt_d;
          hold_q     <= hold_d;
        end
      end
    end else begin : g_no_hold
      assign hold_q = 1'b0;
    end
  endgenerate

  assign btn_state_o = (state_q == BTN_PRESSED);
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign hold_o      = hold_q;
  assign led_o       = led_q;

endmodule

// File: rtl/button_debounce_bank.sv
// N_CH independent debounced pushbutton channels with pulse strobes and follow/toggle LEDs.
module button_debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int LONG_CYC     = 50000,
  parameter bit ACTIVE_HIGH  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in_i,
  input  logic [N_CH-1:0] mode_i,
  output logic [N_CH-1:0] btn_state_o,
  output logic [N_CH-1:0] press_pulse_o,
  output logic [N_CH-1:0] release_pulse_o,
  output logic [N_CH-1:0] hold_pulse_o,
  output logic [N_CH-1:0] led_o
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .ACTIVE_HIGH (ACTIVE_HIGH)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_i      (btn_in_i[g]),
      .mode_i     (mode_i[g]),
      .btn_state_o(btn_state_o[g]),
      .press_o    (press_pulse_o[g]),
      .release_o  (release_pulse_o[g]),
      .hold_o     (hold_pulse_o[g]),
      .led_o      (led_o[g])
    );
  end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Randomized + directed bench: a window-based reference model predicts every output each cycle.
module tb_button_debounce_bank;

  localparam int N  = 2;
  localparam int SS = 2;
  localparam int DC = 8;
  localparam int LC = 32;
  localparam int VW = 5 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn = '0;
  logic [N-1:0] mode = '0;
  logic [N-1:0] st_o, pr_o, rl_o, hd_o, led_o;

  int total = 0;
  int bad   = 0;
  logic [VW-1:0] exp_q[$];

  always #5 clk = ~clk;

  button_debounce_bank #(
    .N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYC(DC), .LONG_CYC(LC), .ACTIVE_HIGH(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in_i(btn), .mode_i(mode),
    .btn_state_o(st_o), .press_pulse_o(pr_o), .release_pulse_o(rl_o),
    .hold_pulse_o(hd_o), .led_o(led_o)
  );

  wire [VW-1:0] dut_vec = {led_o, hd_o, rl_o, pr_o, st_o};

  // Reference: pin history delayed SS edges, level accepted when the last DC delayed
  // samples all disagree with the current level; hold fires LC edges after the press edge.
  initial begin
    bit dly[N][SS];
    bit win[N][DC];
    bit st[N], led[N];
    int press_edge[N];
    int edge_n;
    logic [N-1:0] e_st, e_pr, e_rl, e_hd, e_led;
    bit s, ns, all_neq;
    edge_n = 0;
    forever begin
      @(posedge clk);
      edge_n++;
      e_st = '0; e_pr = '0; e_rl = '0; e_hd = '0; e_led = '0;
      for (int c = 0; c < N; c++) begin
        if (!rst_n) begin
          for (int k = 0; k < SS; k++) dly[c][k] = 1'b0;
          for (int k = 0; k < DC; k++) win[c][k] = 1'b0;
          st[c] = 1'b0; led[c] = 1'b0; press_edge[c] = 0;
        end else begin
          s = dly[c][SS-1];
          for (int k = SS-1; k > 0; k--) dly[c][k] = dly[c][k-1];
          dly[c][0] = btn[c];
          for (int k = DC-1; k > 0; k--) win[c][k] = win[c][k-1];
          win[c][0] = s;
          all_neq = 1'b1;
          for (int k = 0; k < DC; k++) if (win[c][k] == st[c]) all_neq = 1'b0;
          ns = all_neq ? ~st[c] : st[c];
          e_pr[c] = ns & ~st[c];
          e_rl[c] = ~ns & st[c];
          e_hd[c] = st[c] && (edge_n - press_edge[c] == LC);
          if (e_pr[c]) press_edge[c] = edge_n;
          if (!mode[c]) led[c] = ns;
          else if (e_pr[c]) led[c] = ~led[c];
          st[c] = ns;
          e_st[c] = ns;
          e_led[c] = led[c];
        end
      end
      exp_q.push_back({e_led, e_hd, e_rl, e_pr, e_st});
    end
  end

  // Monitor: one expectation per edge, compared 1 time unit after the edge.
  initial begin
    logic [VW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (dut_vec !== e) begin
          bad++;
          $display("FAIL cycle_check t=%0t got led/hold/rel/press/state=%b expected=%b",
                   $time, dut_vec, e);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    total++;
    if (dut_vec !== '0) begin
      bad++;
      $display("FAIL %s got=%b expected=%b", name, dut_vec, {VW{1'b0}});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int rem[N];
    cyc(3);
    rst_n = 1'b1;
    cyc(5);

    // Reset after acceptance, then reset mid-count, then recovery with pins held.
    btn = 2'b11; cyc(14);
    #2 rst_n = 1'b0; #1 check_zero("reset_after_accept");
    cyc(2); rst_n = 1'b1;
    cyc(5);
    #2 rst_n = 1'b0; #1 check_zero("reset_mid_count");
    cyc(2); rst_n = 1'b1;
    cyc(14);
    btn = 2'b00; cyc(15);

    // Bounce rejection on ch0.
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) btn[0] = ~btn[0];
      cyc(1);
    end
    btn[0] = 1'b1; cyc(20);
    btn[0] = 1'b0; cyc(15);

    // Long press and short press on ch1.
    btn[1] = 1'b1; cyc(60);
    btn[1] = 1'b0; cyc(15);
    btn[1] = 1'b1; cyc(30);
    btn[1] = 1'b0; cyc(15);

    // Toggle mode on ch0, then back to follow while released.
    mode[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      btn[0] = 1'b1; cyc(14);
      btn[0] = 1'b0; cyc(14);
    end
    mode[0] = 1'b0; cyc(3);

    // Channel independence: ch1 chatters below the window while ch0 presses.
    btn[0] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k % $urandom_range(1, 5) == 0) btn[1] = ~btn[1];
      cyc(1);
    end
    btn = 2'b00; cyc(15);
    btn = 2'b11; cyc(15);
    btn = 2'b00; cyc(15);

    // Mode change coincident with a press edge on both channels.
    btn = 2'b11; cyc(SS + DC - 1);
    mode = 2'b11; cyc(3);
    btn = 2'b00; cyc(15);

    // Random run lengths straddle the debounce and long-press windows.
    rem[0] = 0; rem[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        if (rem[c] == 0) begin
          btn[c] = ~btn[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(DC, 60) : $urandom_range(1, 12);
        end else begin
          rem[c]--;
        end
        if ($urandom_range(0, 79) == 0) mode[c] = ~mode[c];
      end
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0; #1 check_zero("reset_random");
        cyc(1); rst_n = 1'b1;
      end
      cyc(1);
    end

    btn = 2'b00; cyc(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
